// File: rtl/seq_detect_pkg.sv
// Shared constants and elaboration-time table generators for seq_detect.
package seq_detect_pkg;

  localparam int unsigned DEF_PAT_LEN = 5;
  localparam logic [15:0] DEF_PATTERN = 16'b0000_0000_0001_0010;
  localparam int unsigned MAX_PAT_LEN = 16;
  localparam int unsigned ENT_W       = 8;
  localparam int unsigned TBL_W       = 2 * MAX_PAT_LEN * ENT_W;

  // Width of the state register holding 0..len-1.
  function automatic int unsigned state_width(input int unsigned len);
    return (len < 2) ? 1 : $clog2(len);
  endfunction

  // Pattern bit i in arrival order (i = 0 is the first bit received).
  function automatic logic pat_bit(input logic [15:0] pat, input int unsigned len,
                                   input int unsigned i);
    logic [15:0] sh;
    sh = pat >> (len - 1 - i);
    return sh[0];
  endfunction

  // KMP failure value: longest proper prefix of the first k bits that is also their suffix.
  function automatic int unsigned fail_len(input logic [15:0] pat, input int unsigned len,
                                           input int unsigned k);
    logic ok;
    if (k < 2) return 0;
    for (int unsigned l = k - 1; l > 0; l--) begin
      ok = 1'b1;
      for (int unsigned j = 0; j < l; j++)
        if (pat_bit(pat, len, j) != pat_bit(pat, len, k - l + j)) ok = 1'b0;
      if (ok) return l;
    end
    return 0;
  endfunction

  // Entry {s,b} occupies ENT_W bits: bit 7 = match, bits 4:0 = next state.
  function automatic logic [TBL_W-1:0] gen_table(input logic [15:0] pat, input int unsigned len,
                                                 input bit overlap);
    logic [TBL_W-1:0] tbl;
    logic [ENT_W-1:0] ent;
    logic             bb;
    logic             hit;
    int unsigned      t;
    tbl = '0;
    for (int unsigned s = 0; s < len; s++) begin
      for (int unsigned bv = 0; bv < 2; bv++) begin
        bb  = (bv != 0);
        t   = s;
        hit = 1'b0;
        if (s == len - 1 && pat_bit(pat, len, s) == bb) begin
          hit = 1'b1;
          t   = overlap ? fail_len(pat, len, len) : 0;
        end else begin
          while (t > 0 && pat_bit(pat, len, t) != bb) t = fail_len(pat, len, t);
          if (pat_bit(pat, len, t) == bb) t = t + 1;
        end
        ent      = '0;
        ent[7]   = hit;
        ent[4:0] = 5'(t);
        tbl      = tbl | (TBL_W'(ent) << ((2 * s + bv) * ENT_W));
      end
    end
    return tbl;
  endfunction

endpackage

// File: rtl/seq_detect_nxt.sv
// Combinational next-state and match lookup from the generated transition table.
module seq_detect_nxt
  import seq_detect_pkg::*;
#(
  parameter int unsigned          PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0]   PATTERN = DEF_PATTERN[PAT_LEN-1:0],
  parameter bit                   OVERLAP = 1'b1,
  parameter int unsigned          SW      = state_width(PAT_LEN)
) (
  input  logic [SW-1:0] s,
  input  logic          b,
  output logic [SW-1:0] s_nxt,
  output logic          hit
);

  localparam logic [TBL_W-1:0] TBL = gen_table(16'(PATTERN), PAT_LEN, OVERLAP);

  logic [7:0] base;

  // Select the table entry addressed by {state, bit}; unreachable states fall to 0.
  always_comb begin
    base  = {4'(s), b, 3'b000};
    s_nxt = TBL[base +: SW];
    hit   = TBL[base | 8'd7];
  end

endmodule

// File: rtl/seq_detect.sv
// Serial pattern detector: KMP state register plus registered match pulse.
module seq_detect
  import seq_detect_pkg::*;
#(
  parameter int unsigned        PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN[PAT_LEN-1:0],
  parameter bit                 OVERLAP = 1'b1
) (
  output logic flag,
  input  logic din,
  input  logic clk,
  input  logic rst_n
);

  localparam int unsigned SW = state_width(PAT_LEN);

  logic [SW-1:0] s;
  logic [SW-1:0] s_nxt;
  logic          hit;

  seq_detect_nxt #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP),
    .SW      (SW)
  ) u_nxt (
    .s     (s),
    .b     (din),
    .s_nxt (s_nxt),
    .hit   (hit)
  );

  // State and flag registers; reset clears both without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      flag <= 1'b0;
    end else begin
      s    <= s_nxt;
      flag <= hit;
    end
  end

endmodule

// File: tb/tb_seq_detect.sv
// Self-checking bench for seq_detect (overlapping and non-overlapping instances).
module tb_seq_detect;

  localparam logic [4:0] PAT = 5'b10010;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic flag_o;
  logic flag_n;

  int total = 0;
  int bad   = 0;

  // Reference model state: history and count of bits since reset / last counted match.
  logic [4:0] hist  = '0;
  int         cnt_o = 0;
  int         cnt_n = 0;
  logic       q_o[$];
  logic       q_n[$];

  seq_detect #(.PAT_LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b1)) u_ov (
    .flag (flag_o), .din (din), .clk (clk), .rst_n (rst_n));

  seq_detect #(.PAT_LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b0)) u_nov (
    .flag (flag_n), .din (din), .clk (clk), .rst_n (rst_n));

  initial forever #5 clk = ~clk;

  task automatic model_reset();
    hist  = '0;
    cnt_o = 0;
    cnt_n = 0;
    q_o.delete();
    q_n.delete();
  endtask

  // Drive one bit, push model expectations, then step past the sampling edge.
  task automatic drive_bit(input logic b);
    logic m_o, m_n;
    din  = b;
    hist = {hist[3:0], b};
    if (cnt_o < 5) cnt_o++;
    if (cnt_n < 5) cnt_n++;
    m_o = (cnt_o == 5) && (hist == PAT);
    m_n = (cnt_n == 5) && (hist == PAT);
    if (m_n) cnt_n = 0;
    q_o.push_back(m_o);
    q_n.push_back(m_n);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) begin
      din = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [63:0] bits, sh;
    logic eo, en;
    rst_n = 1'b0;
    model_reset();
    for (int unsigned i = 0; i < 10; i++) begin
      din = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      total++;
      if (flag_o !== 1'b0) begin bad++; $display("FAIL reset_hold[%0d] ov flag=%b exp=0", i, flag_o); end
      total++;
      if (flag_n !== 1'b0) begin bad++; $display("FAIL reset_hold[%0d] nov flag=%b exp=0", i, flag_n); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    bits = 64'b10010;
    for (int unsigned i = 0; i < 5; i++) begin
      sh = bits >> (4 - i);
      drive_bit(sh[0]);
      eo = q_o.pop_front();
      en = q_n.pop_front();
      total++;
      if (flag_o !== eo) begin bad++; $display("FAIL reset_seq[%0d] ov flag=%b exp=%b", i, flag_o, eo); end
      total++;
      if (flag_n !== en) begin bad++; $display("FAIL reset_seq[%0d] nov flag=%b exp=%b", i, flag_n, en); end
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (flag_o !== 1'b0) begin bad++; $display("FAIL reset_async ov flag=%b exp=0", flag_o); end
    total++;
    if (flag_n !== 1'b0) begin bad++; $display("FAIL reset_async nov flag=%b exp=0", flag_n); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_streams();
    logic [63:0] bits [5];
    int          len  [5];
    int          exp_po [5];
    int          exp_pn [5];
    logic [63:0] sh;
    logic        eo, en;
    int          po, pn;
    bits[0] = 64'b10010;                            len[0] = 5;  exp_po[0] = 1; exp_pn[0] = 1;
    bits[1] = 64'b10010010;                         len[1] = 8;  exp_po[1] = 2; exp_pn[1] = 1;
    bits[2] = 64'b1100011001000110101001001010001;  len[2] = 31; exp_po[2] = 3; exp_pn[2] = 2;
    bits[3] = 64'b1000100110010;                    len[3] = 13; exp_po[3] = 1; exp_pn[3] = 1;
    bits[4] = 64'b10010010010;                      len[4] = 11; exp_po[4] = 3; exp_pn[4] = 2;
    for (int unsigned t = 0; t < 5; t++) begin
      do_reset();
      po = 0;
      pn = 0;
      for (int unsigned i = 0; i < 64'(len[t]); i++) begin
        sh = bits[t] >> (64'(len[t]) - 1 - i);
        drive_bit(sh[0]);
        eo = q_o.pop_front();
        en = q_n.pop_front();
        if (flag_o === 1'b1) po++;
        if (flag_n === 1'b1) pn++;
        total++;
        if (flag_o !== eo) begin bad++; $display("FAIL stream%0d[%0d] ov flag=%b exp=%b", t, i + 1, flag_o, eo); end
        total++;
        if (flag_n !== en) begin bad++; $display("FAIL stream%0d[%0d] nov flag=%b exp=%b", t, i + 1, flag_n, en); end
      end
      total++;
      if (po !== exp_po[t]) begin bad++; $display("FAIL stream%0d_pulses ov got=%0d exp=%0d", t, po, exp_po[t]); end
      total++;
      if (pn !== exp_pn[t]) begin bad++; $display("FAIL stream%0d_pulses nov got=%0d exp=%0d", t, pn, exp_pn[t]); end
    end
  endtask

  task automatic test_reset_mid_match();
    logic [63:0] sh;
    logic [63:0] pre, post;
    logic        eo, en;
    int          po;
    do_reset();
    pre = 64'b1001;
    for (int unsigned i = 0; i < 4; i++) begin
      sh = pre >> (3 - i);
      drive_bit(sh[0]);
      eo = q_o.pop_front();
      en = q_n.pop_front();
      total++;
      if (flag_o !== eo) begin bad++; $display("FAIL midrst_pre[%0d] ov flag=%b exp=%b", i, flag_o, eo); end
    end
    #3;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    post = 64'b010010;
    po = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      sh = post >> (5 - i);
      drive_bit(sh[0]);
      eo = q_o.pop_front();
      en = q_n.pop_front();
      if (flag_o === 1'b1) po++;
      total++;
      if (flag_o !== eo) begin bad++; $display("FAIL midrst_post[%0d] ov flag=%b exp=%b", i, flag_o, eo); end
      total++;
      if (flag_n !== en) begin bad++; $display("FAIL midrst_post[%0d] nov flag=%b exp=%b", i, flag_n, en); end
      if (i == 0) begin
        total++;
        if (flag_o !== 1'b0) begin bad++; $display("FAIL midrst_discard ov flag=%b exp=0", flag_o); end
      end
    end
    total++;
    if (po !== 1) begin bad++; $display("FAIL midrst_pulses ov got=%0d exp=1", po); end
  endtask

  task automatic test_random();
    logic eo, en;
    do_reset();
    for (int unsigned i = 0; i < 400; i++) begin
      drive_bit(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0);
      eo = q_o.pop_front();
      en = q_n.pop_front();
      total++;
      if (flag_o !== eo) begin bad++; $display("FAIL random[%0d] ov flag=%b exp=%b", i, flag_o, eo); end
      total++;
      if (flag_n !== en) begin bad++; $display("FAIL random[%0d] nov flag=%b exp=%b", i, flag_n, en); end
    end
  endtask

  initial begin
    test_reset();
    test_streams();
    test_reset_mid_match();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
